iob_uart_multi: RTL

- Parametrised N-channel UART (8N1) behind one IOB CSR subordinate port. Successor to the single-channel testbench UART used in the system-tester simulation harness.
- Adds per-channel RX FIFOs, per-channel baud dividers, framing and overrun detection, and RTS/CTS flow control.
- Sits in simulation tops and in SoC peripheral buses; it replaces one-UART-per-port wiring.

---
 rtl/iob_uart_multi.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/iob_uart_multi.sv
// iob_uart_multi: N-channel 8N1 UART behind one IOB CSR subordinate port.
// Each channel has its own baud divider, a TX path with CTS gating, an RX
// path with framing/overrun detection, a 2^FIFO_AW deep RX FIFO and RTS output.
//
// Ports:
//   clk_i, arst_n_i          clock, asynchronous active-low reset
//   iob_valid_i/addr_i       request; addr = {ch, reg[1:0], 2'b00}
//   iob_wdata_i/wstrb_i      write data, strobes (all-zero = read)
//   iob_ready_o              request accepted (combinational)
//   iob_rvalid_o/rdata_o     read response, registered one cycle after accept
//   rs232_rxd_i/txd_o        serial lines, one bit per channel
//   rs232_rts_o/cts_i        flow control, one bit per channel
//
// Register map per channel: 0 DIV, 1 CTRL/STAT, 2 TXDATA, 3 RXDATA (pop).
module iob_uart_multi #(
    parameter int unsigned       N_CH    = 2,
    parameter int unsigned       FIFO_AW = 4,
    parameter int unsigned       DIV_W   = 16,
    parameter logic [DIV_W-1:0]  DIV_RST = DIV_W'(100),
    parameter int unsigned       ADDR_W  = $clog2(N_CH) + 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              iob_valid_i,
    input  logic [ADDR_W-1:0] iob_addr_i,
    input  logic [31:0]       iob_wdata_i,
    input  logic [3:0]        iob_wstrb_i,
    output logic              iob_rvalid_o,
    output logic [31:0]       iob_rdata_o,
    output logic              iob_ready_o,
    input  logic [N_CH-1:0]   rs232_rxd_i,
    output logic [N_CH-1:0]   rs232_txd_o,
    output logic [N_CH-1:0]   rs232_rts_o,
    input  logic [N_CH-1:0]   rs232_cts_i
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    logic              is_wr;
    logic              acc_wr;
    logic              acc_rd;
    logic              busy_sel;
    logic [31:0]       rdata_d;
    logic [N_CH-1:0]   tx_busy;
    logic [31:0]       rd_word [N_CH];
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              unused_bits;

    assign ch_sel      = iob_addr_i >> 4;
    assign reg_sel     = iob_addr_i[3:2];
    assign is_wr       = |iob_wstrb_i;
    assign unused_bits = ^{iob_wdata_i, iob_addr_i};

    // Out-of-range channels match no entry, so they read 0 and are never busy.
    always_comb begin
        busy_sel = 1'b0;
        rdata_d  = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch_sel == ADDR_W'(c)) begin
                busy_sel = tx_busy[c];
                rdata_d  = rd_word[c];
            end
        end
    end

    // Only a TXDATA write to a busy transmitter is held off.
    assign iob_ready_o = ~(iob_valid_i & is_wr & (reg_sel == 2'd2) & busy_sel);
    assign acc_wr      = iob_valid_i & iob_ready_o & is_wr;
    assign acc_rd      = iob_valid_i & iob_ready_o & ~is_wr;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= acc_rd;
            if (acc_rd) rdata_q <= rdata_d;
        end
    end

    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic              we;
        logic              rd;
        logic [DIV_W-1:0]  div_q;
        logic [DIV_W-1:0]  div_eff;
        logic              tx_en_q;
        logic              rx_en_q;
        logic              ovr_q;
        logic              ferr_q;
        logic              rts_q;
        logic [1:0]        cts_sync_q;
        logic [1:0]        rxd_sync_q;
        logic              cts_s;
        logic              rxd_s;
        logic [7:0]        mem_q [DEPTH];
        logic [FIFO_AW-1:0] wptr_q;
        logic [FIFO_AW-1:0] rptr_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              empty;
        logic              full;
        logic              push;
        logic              pop;
        logic [31:0]       rword;
        tx_state_e         tx_state_q;
        logic [DIV_W-1:0]  tx_cnt_q;
        logic [2:0]        tx_bit_q;
        logic [7:0]        tx_sh_q;
        logic              txd_q;
        logic              tx_tick;
        rx_state_e         rx_state_q;
        logic [DIV_W-1:0]  rx_cnt_q;
        logic [2:0]        rx_bit_q;
        logic [7:0]        rx_sh_q;
        logic              rxd_prev_q;
        logic              rx_push_q;
        logic [7:0]        rx_byte_q;
        logic              rx_ferr_q;
        logic              rx_tick;
        logic              rx_half;

        assign we      = acc_wr & (ch_sel == ADDR_W'(c));
        assign rd      = acc_rd & (ch_sel == ADDR_W'(c));
        assign div_eff = (div_q < DIV_W'(4)) ? DIV_W'(4) : div_q;
        assign cts_s   = cts_sync_q[1];
        assign rxd_s   = rxd_sync_q[1];

        // rxd synchronizer resets to idle-high so reset release is not seen as a start edge.
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                cts_sync_q <= '0;
                rxd_sync_q <= '1;
            end else begin
                cts_sync_q <= {cts_sync_q[0], rs232_cts_i[c]};
                rxd_sync_q <= {rxd_sync_q[0], rs232_rxd_i[c]};
            end
        end

        // FIFO: pop only when non-empty; a push into a full FIFO survives only with a pop.
        assign empty = (cnt_q == '0);
        assign full  = (cnt_q == CNT_W'(DEPTH));
        assign pop   = rd & (reg_sel == 2'd3) & ~empty;
        assign push  = rx_push_q & (~full | pop);

        always_ff @(posedge clk_i) begin
            if (push) mem_q[wptr_q] <= rx_byte_q;
        end

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
                if (push & ~pop)      cnt_q <= cnt_q + 1'b1;
                else if (pop & ~push) cnt_q <= cnt_q - 1'b1;
            end
        end

        // Control registers and sticky flags; hardware set wins over W1C.
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                div_q   <= DIV_RST;
                tx_en_q <= 1'b0;
                rx_en_q <= 1'b0;
                ovr_q   <= 1'b0;
                ferr_q  <= 1'b0;
                rts_q   <= 1'b0;
            end else begin
                if (we && reg_sel == 2'd0) div_q <= iob_wdata_i[DIV_W-1:0];
                if (we && reg_sel == 2'd1) begin
                    tx_en_q <= iob_wdata_i[0];
                    rx_en_q <= iob_wdata_i[1];
                    if (iob_wdata_i[5]) ovr_q  <= 1'b0;
                    if (iob_wdata_i[6]) ferr_q <= 1'b0;
                end
                if (rx_push_q & full & ~pop) ovr_q  <= 1'b1;
                if (rx_ferr_q)               ferr_q <= 1'b1;
                rts_q <= rx_en_q & (cnt_q < CNT_W'(DEPTH - 2));
            end
        end

        always_comb begin
            rword = '0;
            case (reg_sel)
                2'd0: rword[DIV_W-1:0] = div_q;
                2'd1: begin
                    rword[0]          = tx_en_q;
                    rword[1]          = rx_en_q;
                    rword[2]          = tx_busy[c];
                    rword[3]          = empty;
                    rword[4]          = full;
                    rword[5]          = ovr_q;
                    rword[6]          = ferr_q;
                    rword[8 +: CNT_W] = cnt_q;
                end
                2'd3: rword[7:0] = empty ? 8'h00 : mem_q[rptr_q];
                default: ;
            endcase
        end
        assign rd_word[c] = rword;

        // TX: txd_q is updated on each state entry, so every bit lasts div_eff cycles.
        assign tx_tick    = (tx_cnt_q >= div_eff - 1'b1);
        assign tx_busy[c] = (tx_state_q != TX_IDLE);

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                tx_state_q <= TX_IDLE;
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
                tx_sh_q    <= '0;
                txd_q      <= 1'b1;
            end else begin
                tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 1'b1;
                case (tx_state_q)
                    TX_IDLE: if (we && reg_sel == 2'd2) begin
                        tx_sh_q    <= iob_wdata_i[7:0];
                        tx_state_q <= TX_WAIT;
                    end
                    TX_WAIT: if (tx_en_q && cts_s) begin
                        tx_state_q <= TX_START;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= '0;
                    end
                    TX_START: if (tx_tick) begin
                        tx_state_q <= TX_DATA;
                        txd_q      <= tx_sh_q[0];
                        tx_sh_q    <= tx_sh_q >> 1;
                        tx_bit_q   <= '0;
                    end
                    TX_DATA: if (tx_tick) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            txd_q    <= tx_sh_q[0];
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_bit_q <= tx_bit_q + 1'b1;
                        end
                    end
                    TX_STOP: if (tx_tick) tx_state_q <= TX_IDLE;
                    default: tx_state_q <= TX_IDLE;
                endcase
            end
        end

        // RX: start is re-checked half a bit after the falling edge, then
        // data/stop are sampled once per bit period.
        assign rx_tick = (rx_cnt_q >= div_eff - 1'b1);
        assign rx_half = (rx_cnt_q >= (div_eff >> 1) - 1'b1);

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                rx_state_q <= RX_IDLE;
                rx_cnt_q   <= '0;
                rx_bit_q   <= '0;
                rx_sh_q    <= '0;
                rxd_prev_q <= 1'b1;
                rx_push_q  <= 1'b0;
                rx_byte_q  <= '0;
                rx_ferr_q  <= 1'b0;
            end else begin
                rxd_prev_q <= rxd_s;
                rx_push_q  <= 1'b0;
                rx_ferr_q  <= 1'b0;
                rx_cnt_q   <= rx_tick ? '0 : rx_cnt_q + 1'b1;
                if (!rx_en_q) begin
                    rx_state_q <= RX_IDLE;
                end else begin
                    case (rx_state_q)
                        RX_IDLE: if (rxd_prev_q && !rxd_s) begin
                            rx_state_q <= RX_START;
                            rx_cnt_q   <= '0;
                        end
                        RX_START: if (rx_half) begin
                            rx_cnt_q   <= '0;
                            rx_bit_q   <= '0;
                            rx_state_q <= rxd_s ? RX_IDLE : RX_DATA;
                        end
                        RX_DATA: if (rx_tick) begin
                            rx_sh_q <= {rxd_s, rx_sh_q[7:1]};
                            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                            else                  rx_bit_q   <= rx_bit_q + 1'b1;
                        end
                        RX_STOP: if (rx_tick) begin
                            rx_state_q <= RX_IDLE;
                            if (rxd_s) begin
                                rx_push_q <= 1'b1;
                                rx_byte_q <= rx_sh_q;
                            end else begin
                                rx_ferr_q <= 1'b1;
                            end
                        end
                        default: rx_state_q <= RX_IDLE;
                    endcase
                end
            end
        end

        assign rs232_txd_o[c] = txd_q;
        assign rs232_rts_o[c] = rts_q;
    end

endmodule
